// File: rtl/axi4_instr_seq_if.sv
// Instruction beat stream between the host DMA (master) and axi4_instr_seq (slave).
interface axi4_instr_seq_if #(
  parameter int TDATA_WIDTH = 512
) ();
  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA;
  logic                   S_AXIS_TVALID;
  logic                   S_AXIS_TREADY;

  modport master (output S_AXIS_TDATA, output S_AXIS_TVALID, input S_AXIS_TREADY);
  modport slave  (input S_AXIS_TDATA, input S_AXIS_TVALID, output S_AXIS_TREADY);
endinterface

// File: rtl/axi4_instr_seq.sv
// AXI4-Stream instruction sequencer: buffers beats, issues LANES DDR4 command slots per clock.
// Optional statistics counters are enabled by defining AXI4_INSTR_SEQ_STATS_EN.
module axi4_instr_seq #(
  parameter int TDATA_WIDTH = 512,
  parameter int INSTR_WIDTH = 32,
  parameter int LANES       = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int BG_WIDTH    = 2,
  parameter int BANK_WIDTH  = 2,
  parameter int COL_WIDTH   = 10,
  parameter int ROW_WIDTH   = 17
) (
  input  logic                        clk,
  input  logic                        rst_n,
  axi4_instr_seq_if.slave             s_axis,
  input  logic                        cmd_ready,
  output logic                        cmd_valid,
  output logic [2:0]                  dbg_opcode,
  output logic [LANES-1:0]            ddr_write,
  output logic [LANES-1:0]            ddr_read,
  output logic [LANES-1:0]            ddr_pre,
  output logic [LANES-1:0]            ddr_act,
  output logic [LANES-1:0]            ddr_ref,
  output logic [LANES-1:0]            ddr_zq,
  output logic [LANES-1:0]            ddr_nop,
  output logic [LANES-1:0]            ddr_ap,
  output logic [LANES-1:0]            ddr_half_bl,
  output logic [LANES-1:0]            ddr_pall,
  output logic [LANES*BG_WIDTH-1:0]   ddr_bg,
  output logic [LANES*BANK_WIDTH-1:0] ddr_bank,
  output logic [LANES*COL_WIDTH-1:0]  ddr_col,
  output logic [LANES*ROW_WIDTH-1:0]  ddr_row
`ifdef AXI4_INSTR_SEQ_STATS_EN
  ,
  output logic [31:0]                 stat_cmds,
  output logic [31:0]                 stat_wait_cycles
`endif
);

  localparam int GROUP_WIDTH = INSTR_WIDTH * LANES;
  localparam int NUM_GROUPS  = TDATA_WIDTH / GROUP_WIDTH;
  localparam int GRP_IDX_W   = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int RC_LSB      = 3 + BANK_WIDTH + BG_WIDTH;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PRE  = 3'd1;
  localparam logic [2:0] OP_ACT  = 3'd2;
  localparam logic [2:0] OP_RD   = 3'd3;
  localparam logic [2:0] OP_WR   = 3'd4;
  localparam logic [2:0] OP_REF  = 3'd5;
  localparam logic [2:0] OP_ZQ   = 3'd6;
  localparam logic [2:0] OP_WAIT = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  typedef struct packed {
    logic [LANES-1:0]            write;
    logic [LANES-1:0]            read;
    logic [LANES-1:0]            pre;
    logic [LANES-1:0]            act;
    logic [LANES-1:0]            refresh;
    logic [LANES-1:0]            zq;
    logic [LANES-1:0]            nop;
    logic [LANES-1:0]            ap;
    logic [LANES-1:0]            half_bl;
    logic [LANES-1:0]            pall;
    logic [LANES*BG_WIDTH-1:0]   bg;
    logic [LANES*BANK_WIDTH-1:0] bank;
    logic [LANES*COL_WIDTH-1:0]  col;
    logic [LANES*ROW_WIDTH-1:0]  row;
    logic [2:0]                  opcode0;
  } group_t;

  logic [TDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [TDATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                   fifo_empty, fifo_full, push, pop;

  state_t                 state_q, state_d;
  logic [GRP_IDX_W-1:0]   grp_q, grp_d;
  group_t                 out_q, out_d, dec, idle_out;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [15:0]            wait_cnt_q, wait_cnt_d, wait_max_q, wait_max_d, dec_wait_max;
  logic [TDATA_WIDTH-1:0] head_beat;
  logic [GROUP_WIDTH-1:0] grp_bits;
  logic [2:0]             lane_op;
  logic [15:0]            lane_cnt;
  logic                   load_grp;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign s_axis.S_AXIS_TREADY = rst_n && !fifo_full;
  assign push       = s_axis.S_AXIS_TVALID && s_axis.S_AXIS_TREADY;
  assign head_beat  = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign grp_bits   = head_beat[grp_q*GROUP_WIDTH +: GROUP_WIDTH];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = s_axis.S_AXIS_TDATA;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Decode the head group; WAIT lanes show as NOP and contribute their count to the group maximum.
  always_comb begin
    dec          = '0;
    dec_wait_max = '0;
    lane_op      = '0;
    lane_cnt     = '0;
    dec.opcode0  = grp_bits[2:0];
    for (int l = 0; l < LANES; l++) begin
      lane_op  = grp_bits[l*INSTR_WIDTH +: 3];
      lane_cnt = grp_bits[l*INSTR_WIDTH+3 +: 16];
      case (lane_op)
        OP_PRE: begin
          dec.pre[l]  = 1'b1;
          dec.pall[l] = grp_bits[l*INSTR_WIDTH+RC_LSB];
        end
        OP_ACT: dec.act[l] = 1'b1;
        OP_RD: begin
          dec.read[l]    = 1'b1;
          dec.ap[l]      = grp_bits[l*INSTR_WIDTH+INSTR_WIDTH-1];
          dec.half_bl[l] = grp_bits[l*INSTR_WIDTH+INSTR_WIDTH-2];
        end
        OP_WR: begin
          dec.write[l]   = 1'b1;
          dec.ap[l]      = grp_bits[l*INSTR_WIDTH+INSTR_WIDTH-1];
          dec.half_bl[l] = grp_bits[l*INSTR_WIDTH+INSTR_WIDTH-2];
        end
        OP_REF: dec.refresh[l] = 1'b1;
        OP_ZQ:  dec.zq[l] = 1'b1;
        OP_WAIT: begin
          dec.nop[l] = 1'b1;
          if (lane_cnt > dec_wait_max) dec_wait_max = lane_cnt;
        end
        default: dec.nop[l] = 1'b1;
      endcase
      if (lane_op != OP_NOP && lane_op != OP_WAIT) begin
        dec.bank[l*BANK_WIDTH +: BANK_WIDTH] = grp_bits[l*INSTR_WIDTH+3 +: BANK_WIDTH];
        dec.bg[l*BG_WIDTH +: BG_WIDTH]       = grp_bits[l*INSTR_WIDTH+3+BANK_WIDTH +: BG_WIDTH];
        dec.col[l*COL_WIDTH +: COL_WIDTH]    = grp_bits[l*INSTR_WIDTH+RC_LSB +: COL_WIDTH];
        dec.row[l*ROW_WIDTH +: ROW_WIDTH]    = grp_bits[l*INSTR_WIDTH+RC_LSB +: ROW_WIDTH];
      end
    end
  end

  // Outputs are a registered stage: a new group loads when the previous one is accepted or absent.
  always_comb begin
    idle_out     = '0;
    idle_out.nop = '1;
    state_d      = state_q;
    grp_d        = grp_q;
    out_d        = out_q;
    cmd_valid_d  = cmd_valid_q;
    wait_cnt_d   = wait_cnt_q;
    wait_max_d   = wait_max_q;
    pop          = 1'b0;
    load_grp     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        out_d       = idle_out;
        cmd_valid_d = 1'b0;
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!cmd_valid_q || cmd_ready) begin
          if (cmd_valid_q && wait_max_q != '0) begin
            state_d     = ST_WAIT;
            wait_cnt_d  = wait_max_q;
            out_d       = idle_out;
            cmd_valid_d = 1'b0;
          end else if (!fifo_empty) begin
            load_grp = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            out_d       = idle_out;
            cmd_valid_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (cmd_ready) begin
          if (wait_cnt_q > 16'd1) begin
            wait_cnt_d = wait_cnt_q - 16'd1;
          end else if (!fifo_empty) begin
            load_grp = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_grp) begin
      state_d     = ST_ISSUE;
      out_d       = dec;
      cmd_valid_d = 1'b1;
      wait_max_d  = dec_wait_max;
      wait_cnt_d  = '0;
      if (grp_q == GRP_IDX_W'(NUM_GROUPS - 1)) begin
        grp_d = '0;
        pop   = 1'b1;
      end else begin
        grp_d = grp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      grp_q       <= '0;
      out_q       <= '0;
      cmd_valid_q <= 1'b0;
      wait_cnt_q  <= '0;
      wait_max_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      grp_q       <= grp_d;
      out_q       <= out_d;
      cmd_valid_q <= cmd_valid_d;
      wait_cnt_q  <= wait_cnt_d;
      wait_max_q  <= wait_max_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign cmd_valid   = cmd_valid_q;
  assign dbg_opcode  = out_q.opcode0;
  assign ddr_write   = out_q.write;
  assign ddr_read    = out_q.read;
  assign ddr_pre     = out_q.pre;
  assign ddr_act     = out_q.act;
  assign ddr_ref     = out_q.refresh;
  assign ddr_zq      = out_q.zq;
  assign ddr_nop     = out_q.nop;
  assign ddr_ap      = out_q.ap;
  assign ddr_half_bl = out_q.half_bl;
  assign ddr_pall    = out_q.pall;
  assign ddr_bg      = out_q.bg;
  assign ddr_bank    = out_q.bank;
  assign ddr_col     = out_q.col;
  assign ddr_row     = out_q.row;

`ifdef AXI4_INSTR_SEQ_STATS_EN
  logic [31:0] stat_cmds_q, stat_cmds_d, stat_wait_q, stat_wait_d, cmd_lanes;
  logic [32:0] cmds_sum;

  // A lane counts as a command exactly when its NOP strobe is low in an accepted group.
  always_comb begin
    stat_cmds_d = stat_cmds_q;
    stat_wait_d = stat_wait_q;
    cmd_lanes   = '0;
    cmds_sum    = '0;
    for (int l = 0; l < LANES; l++) begin
      if (!out_q.nop[l]) cmd_lanes = cmd_lanes + 32'd1;
    end
    if (cmd_valid_q && cmd_ready) begin
      cmds_sum    = {1'b0, stat_cmds_q} + {1'b0, cmd_lanes};
      stat_cmds_d = cmds_sum[32] ? '1 : cmds_sum[31:0];
    end
    if (state_q == ST_WAIT && cmd_ready && stat_wait_q != '1) stat_wait_d = stat_wait_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cmds_q <= '0;
      stat_wait_q <= '0;
    end else begin
      stat_cmds_q <= stat_cmds_d;
      stat_wait_q <= stat_wait_d;
    end
  end

  assign stat_cmds        = stat_cmds_q;
  assign stat_wait_cycles = stat_wait_q;
`endif

endmodule

// File: tb/tb_axi4_instr_seq.sv
// Directed self-checking bench for axi4_instr_seq at default parameters.
// Define AXI4_INSTR_SEQ_STATS_EN to also check the statistics counters.
module tb_axi4_instr_seq;
  localparam int TDATA_WIDTH = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_ready, cmd_valid;
  logic [2:0]  dbg_opcode;
  logic [3:0]  ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq;
  logic [3:0]  ddr_nop, ddr_ap, ddr_half_bl, ddr_pall;
  logic [7:0]  ddr_bg, ddr_bank;
  logic [39:0] ddr_col;
  logic [67:0] ddr_row;
`ifdef AXI4_INSTR_SEQ_STATS_EN
  logic [31:0] stat_cmds, stat_wait_cycles;
`endif
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi4_instr_seq_if #(.TDATA_WIDTH(TDATA_WIDTH)) s_axis ();

  axi4_instr_seq dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_axis), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .dbg_opcode(dbg_opcode),
    .ddr_write(ddr_write), .ddr_read(ddr_read), .ddr_pre(ddr_pre), .ddr_act(ddr_act),
    .ddr_ref(ddr_ref), .ddr_zq(ddr_zq), .ddr_nop(ddr_nop), .ddr_ap(ddr_ap),
    .ddr_half_bl(ddr_half_bl), .ddr_pall(ddr_pall), .ddr_bg(ddr_bg), .ddr_bank(ddr_bank),
    .ddr_col(ddr_col), .ddr_row(ddr_row)
`ifdef AXI4_INSTR_SEQ_STATS_EN
    , .stat_cmds(stat_cmds), .stat_wait_cycles(stat_wait_cycles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    s_axis.S_AXIS_TVALID = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Every lane is an ACT whose row encodes beat number and instruction index.
  function automatic logic [TDATA_WIDTH-1:0] act_beat(int b);
    logic [TDATA_WIDTH-1:0] beat;
    beat = '0;
    for (int i = 0; i < 16; i++) beat[i*32 +: 32] = {8'd0, 17'(b*256 + i), 4'd0, 3'd2};
    return beat;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_ready = 1'b0;
    s_axis.S_AXIS_TVALID = 1'b0;
    s_axis.S_AXIS_TDATA = '0;
    tick();
    tick();
    vectors++;
    if ({cmd_valid, dbg_opcode, ddr_nop, ddr_write, ddr_read, ddr_act, ddr_row} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got valid=%b nop=%b row=%h, expected all 0", cmd_valid, ddr_nop, ddr_row);
    end
    vectors++;
    if (s_axis.S_AXIS_TREADY !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_tready: got %b expected 0", s_axis.S_AXIS_TREADY);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (s_axis.S_AXIS_TREADY !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_tready_release: got %b expected 1", s_axis.S_AXIS_TREADY);
    end
    tick();
    vectors++;
    if ({cmd_valid, dbg_opcode, ddr_nop} !== {1'b0, 3'd0, 4'b1111}) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got valid=%b dbg=%0d nop=%b expected 0/0/1111", cmd_valid, dbg_opcode, ddr_nop);
    end
  endtask

  task automatic test_basic_issue();
    logic [TDATA_WIDTH-1:0] beat;
    apply_reset();
    beat = '0;
    for (int i = 0; i < 16; i++) beat[i*32 +: 32] = 32'(i % 6);
    cmd_ready = 1'b1;
    s_axis.S_AXIS_TDATA = beat;
    s_axis.S_AXIS_TVALID = 1'b1;
    tick();
    s_axis.S_AXIS_TVALID = 1'b0;
    tick();
    vectors++;
    if (cmd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got valid=%b at t+1 expected 0", cmd_valid);
    end
    tick();
    vectors++;
    if ({cmd_valid, dbg_opcode, ddr_nop, ddr_pre, ddr_act, ddr_read} !== {1'b1, 3'd0, 16'b0001_0010_0100_1000}) begin
      miscompares++;
      $display("[TB] FAIL basic_g0: got v=%b op=%0d nop=%b pre=%b act=%b rd=%b", cmd_valid, dbg_opcode, ddr_nop, ddr_pre, ddr_act, ddr_read);
    end
    tick();
    vectors++;
    if ({cmd_valid, dbg_opcode, ddr_write, ddr_ref, ddr_nop, ddr_pre} !== {1'b1, 3'd4, 16'b0001_0010_0100_1000}) begin
      miscompares++;
      $display("[TB] FAIL basic_g1: got v=%b op=%0d wr=%b ref=%b nop=%b pre=%b", cmd_valid, dbg_opcode, ddr_write, ddr_ref, ddr_nop, ddr_pre);
    end
    tick();
    vectors++;
    if ({cmd_valid, dbg_opcode, ddr_act, ddr_read, ddr_write, ddr_ref} !== {1'b1, 3'd2, 16'b0001_0010_0100_1000}) begin
      miscompares++;
      $display("[TB] FAIL basic_g2: got v=%b op=%0d act=%b rd=%b wr=%b ref=%b", cmd_valid, dbg_opcode, ddr_act, ddr_read, ddr_write, ddr_ref);
    end
    tick();
    vectors++;
    if ({cmd_valid, dbg_opcode, ddr_nop, ddr_pre, ddr_act, ddr_read} !== {1'b1, 3'd0, 16'b0001_0010_0100_1000}) begin
      miscompares++;
      $display("[TB] FAIL basic_g3: got v=%b op=%0d nop=%b pre=%b act=%b rd=%b", cmd_valid, dbg_opcode, ddr_nop, ddr_pre, ddr_act, ddr_read);
    end
    tick();
    vectors++;
    if ({cmd_valid, ddr_nop} !== {1'b0, 4'b1111}) begin
      miscompares++;
      $display("[TB] FAIL basic_end_idle: got valid=%b nop=%b expected 0/1111", cmd_valid, ddr_nop);
    end
  endtask

  task automatic test_back_to_back();
    int exp_row;
    apply_reset();
    cmd_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      s_axis.S_AXIS_TDATA = act_beat(b);
      s_axis.S_AXIS_TVALID = 1'b1;
      tick();
    end
    s_axis.S_AXIS_TVALID = 1'b0;
    for (int j = 0; j < 12; j++) begin
      exp_row = (j / 4) * 256 + (j % 4) * 4;
      vectors++;
      if ({cmd_valid, ddr_row[16:0]} !== {1'b1, 17'(exp_row)}) begin
        miscompares++;
        $display("[TB] FAIL b2b_cycle%0d: got valid=%b row=%h expected 1/%h", j, cmd_valid, ddr_row[16:0], exp_row);
      end
      tick();
    end
    vectors++;
    if (cmd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_tail: got valid=%b expected 0", cmd_valid);
    end
  endtask

  task automatic test_wait_opcode();
    logic [TDATA_WIDTH-1:0] beat;
    apply_reset();
    beat = '0;
    beat[31:0]   = 32'h0000_002F;
    beat[63:32]  = 32'h00D5_E6B2;
    beat[95:64]  = 32'h0000_001F;
    beat[127:96] = 32'h8000_0003;
    cmd_ready = 1'b1;
    s_axis.S_AXIS_TDATA = beat;
    s_axis.S_AXIS_TVALID = 1'b1;
    tick();
    s_axis.S_AXIS_TVALID = 1'b0;
    tick();
    tick();
    vectors++;
    if ({cmd_valid, dbg_opcode, ddr_act, ddr_read, ddr_ap, ddr_nop, ddr_half_bl, ddr_pall} !==
        {1'b1, 3'd7, 4'b0010, 4'b1000, 4'b1000, 4'b0101, 4'b0000, 4'b0000}) begin
      miscompares++;
      $display("[TB] FAIL wait_g0_strobes: got v=%b op=%0d act=%b rd=%b ap=%b nop=%b hb=%b pall=%b",
               cmd_valid, dbg_opcode, ddr_act, ddr_read, ddr_ap, ddr_nop, ddr_half_bl, ddr_pall);
    end
    vectors++;
    if ({ddr_row, ddr_col, ddr_bank, ddr_bg} !== {68'h1ABCD << 17, 40'h3CD << 10, 8'b0000_1000, 8'b0000_0100}) begin
      miscompares++;
      $display("[TB] FAIL wait_g0_fields: got row=%h col=%h bank=%b bg=%b", ddr_row, ddr_col, ddr_bank, ddr_bg);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if ({cmd_valid, dbg_opcode, ddr_nop, ddr_act, ddr_read} !== {1'b0, 3'd0, 4'b1111, 8'd0}) begin
        miscompares++;
        $display("[TB] FAIL wait_idle%0d: got v=%b op=%0d nop=%b act=%b rd=%b", c, cmd_valid, dbg_opcode, ddr_nop, ddr_act, ddr_read);
      end
    end
    tick();
    vectors++;
    if ({cmd_valid, dbg_opcode, ddr_nop} !== {1'b1, 3'd0, 4'b1111}) begin
      miscompares++;
      $display("[TB] FAIL wait_g1: got v=%b op=%0d nop=%b expected 1/0/1111", cmd_valid, dbg_opcode, ddr_nop);
    end
    tick();
    tick();
    tick();
    vectors++;
    if (cmd_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wait_drain: got valid=%b expected 0", cmd_valid);
    end
`ifdef AXI4_INSTR_SEQ_STATS_EN
    vectors++;
    if ({stat_cmds, stat_wait_cycles} !== {32'd2, 32'd5}) begin
      miscompares++;
      $display("[TB] FAIL stats: got cmds=%0d waits=%0d expected 2/5", stat_cmds, stat_wait_cycles);
    end
`endif
  endtask

  task automatic test_backpressure();
    int next_beat, idx, cyc, exp_row;
    logic acc;
    apply_reset();
    cmd_ready = 1'b1;
    s_axis.S_AXIS_TDATA = act_beat(0);
    s_axis.S_AXIS_TVALID = 1'b1;
    tick();
    s_axis.S_AXIS_TVALID = 1'b0;
    tick();
    tick();
    tick();
    cmd_ready = 1'b0;
    next_beat = 1;
    for (int c = 0; c < 7; c++) begin
      s_axis.S_AXIS_TDATA = act_beat(next_beat);
      s_axis.S_AXIS_TVALID = 1'b1;
      acc = s_axis.S_AXIS_TREADY;
      tick();
      if (acc) next_beat++;
      vectors++;
      if ({cmd_valid, dbg_opcode, ddr_row[16:0]} !== {1'b1, 3'd2, 17'd4}) begin
        miscompares++;
        $display("[TB] FAIL bp_frozen%0d: got v=%b op=%0d row=%h expected 1/2/4", c, cmd_valid, dbg_opcode, ddr_row[16:0]);
      end
    end
    vectors++;
    if ({s_axis.S_AXIS_TREADY, 3'(next_beat)} !== {1'b0, 3'd4}) begin
      miscompares++;
      $display("[TB] FAIL bp_full: got tready=%b next_beat=%0d expected 0/4", s_axis.S_AXIS_TREADY, next_beat);
    end
    cmd_ready = 1'b1;
    idx = 0;
    cyc = 0;
    while (idx < 23 && cyc < 200) begin
      if (cmd_valid === 1'b1) begin
        exp_row = (idx < 3) ? 4 * (idx + 1) : ((idx - 3) / 4 + 1) * 256 + ((idx - 3) % 4) * 4;
        vectors++;
        if (ddr_row[16:0] !== 17'(exp_row)) begin
          miscompares++;
          $display("[TB] FAIL bp_order%0d: got row=%h expected %h", idx, ddr_row[16:0], exp_row);
        end
        idx++;
      end
      acc = 1'b0;
      if (next_beat <= 5) begin
        s_axis.S_AXIS_TDATA = act_beat(next_beat);
        s_axis.S_AXIS_TVALID = 1'b1;
        acc = s_axis.S_AXIS_TREADY;
      end else begin
        s_axis.S_AXIS_TVALID = 1'b0;
      end
      tick();
      cyc++;
      if (acc) next_beat++;
    end
    s_axis.S_AXIS_TVALID = 1'b0;
    vectors++;
    if (idx != 23) begin
      miscompares++;
      $display("[TB] FAIL bp_count: got %0d groups expected 23", idx);
    end
    tick();
    vectors++;
    if ({cmd_valid, ddr_nop} !== {1'b0, 4'b1111}) begin
      miscompares++;
      $display("[TB] FAIL bp_no_dup: got valid=%b nop=%b expected 0/1111", cmd_valid, ddr_nop);
    end
  endtask

  task automatic test_reset_mid_beat();
    apply_reset();
    cmd_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      s_axis.S_AXIS_TDATA = act_beat(b);
      s_axis.S_AXIS_TVALID = 1'b1;
      tick();
    end
    s_axis.S_AXIS_TVALID = 1'b0;
    tick();
    tick();
    vectors++;
    if ({cmd_valid, ddr_row[16:0]} !== {1'b1, 17'd8}) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_pre: got valid=%b row=%h expected 1/8", cmd_valid, ddr_row[16:0]);
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if ({cmd_valid, dbg_opcode, ddr_nop, ddr_act, ddr_row, s_axis.S_AXIS_TREADY} !== '0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_zero: got v=%b nop=%b act=%b tready=%b expected all 0", cmd_valid, ddr_nop, ddr_act, s_axis.S_AXIS_TREADY);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (s_axis.S_AXIS_TREADY !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_tready: got %b expected 1", s_axis.S_AXIS_TREADY);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      vectors++;
      if ({cmd_valid, ddr_nop, ddr_act} !== {1'b0, 4'b1111, 4'b0000}) begin
        miscompares++;
        $display("[TB] FAIL rst_mid_idle%0d: got v=%b nop=%b act=%b expected 0/1111/0000", c, cmd_valid, ddr_nop, ddr_act);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_back_to_back();
    test_wait_opcode();
    test_backpressure();
    test_reset_mid_beat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end
endmodule
